matrix_strip_rx: RTL

Receiver/checker for the serial LED-strip stream the 8x8 matrix driver emits on its clock/data outputs (32 zero start bits, one 32-bit word per LED `111`+brightness[4:0]+B+G+R, trailing zeros). Sits directly downstream of the matrix driver: it samples the strip clock and data with the system clock, decodes each LED word, undoes the snake wiring and rebuilds the 64-bit display bitmap. It serves as the on-chip loop-back monitor and as the bench's golden decoder.

---
 rtl/matrix_pkg.sv | 37 +++
 rtl/strip_edge_sync.sv | 69 ++++++
 rtl/matrix_strip_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Brief    : Shared types and constants for the LED-strip matrix path.
// Revision : 1.0
// ============================================================================
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_WORD = 2'd1,
        ST_DONE = 2'd2
    } rx_state_e;

    localparam int          START_ZEROS = 32;
    localparam logic [2:0]  LED_HDR     = 3'b111;
    localparam int          WORD_W      = 32;
    localparam logic [31:0] NUM_COLOUR  = 32'hf0000f00;
    localparam logic [31:0] BG_COLOUR   = 32'hf0070000;

    // Physical strip position -> logical display index; even rows run right-to-left.
    function automatic logic [5:0] unsnake(input logic [5:0] p, input int row_len);
        int row;
        int col;
        int idx;
        row = int'(p) / row_len;
        col = int'(p) % row_len;
        if (row[0] == 1'b0) begin
            idx = row * row_len + (row_len - 1 - col);
        end else begin
            idx = int'(p);
        end
        return idx[5:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/strip_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : strip_edge_sync
// Brief    : Optional synchroniser plus rising-edge detector for the strip clock.
// Revision : 1.0
// ============================================================================
module strip_edge_sync #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic strip_clk,
    input  logic strip_data,
    output logic bit_evt,
    output logic bit_val
);

    logic clk_s;
    logic data_s;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign clk_s  = strip_clk;
            assign data_s = strip_data;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] clk_sync_q;
            logic [SYNC_STAGES-1:0] data_sync_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    clk_sync_q  <= '0;
                    data_sync_q <= '0;
                end else begin
                    clk_sync_q[0]  <= strip_clk;
                    data_sync_q[0] <= strip_data;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        clk_sync_q[i]  <= clk_sync_q[i-1];
                        data_sync_q[i] <= data_sync_q[i-1];
                    end
                end
            end

            assign clk_s  = clk_sync_q[SYNC_STAGES-1];
            assign data_s = data_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic clk_q;
    logic clk_prev_q;
    logic data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_q      <= 1'b0;
            clk_prev_q <= 1'b0;
            data_q     <= 1'b0;
        end else begin
            clk_q      <= clk_s;
            clk_prev_q <= clk_q;
            data_q     <= data_s;
        end
    end

    // Data comes from the same stage as the edge so it is the value present at the rise.
    assign bit_evt = clk_q & ~clk_prev_q;
    assign bit_val = data_q;

endmodule
`default_nettype wire

// File: rtl/matrix_strip_rx.sv
`default_nettype none
// ============================================================================
// Module   : matrix_strip_rx
// Brief    : Decodes the serial LED-strip stream back into pixels and a bitmap.
// Revision : 1.0
// ============================================================================
module matrix_strip_rx
    import matrix_pkg::*;
#(
    parameter int          NUM_LEDS    = 64,
    parameter int          ROW_LEN     = 8,
    parameter logic [31:0] ON_WORD     = 32'hf0000f00,
    parameter int          SYNC_STAGES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strip_clk,
    input  logic        strip_data,
    output logic        pix_valid,
    output logic [5:0]  pix_addr,
    output logic [4:0]  pix_bright,
    output logic [7:0]  pix_b,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_r,
    output logic        frame_done,
    output logic [63:0] bitmap,
    output logic [7:0]  frame_cnt,
    output logic        hdr_err
);

    logic bit_evt;
    logic bit_val;

    strip_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk        (clk),
        .reset      (reset),
        .strip_clk  (strip_clk),
        .strip_data (strip_data),
        .bit_evt    (bit_evt),
        .bit_val    (bit_val)
    );

    rx_state_e          state_q,      state_d;
    logic [5:0]         zcnt_q,       zcnt_d;
    logic [5:0]         bitcnt_q,     bitcnt_d;
    logic [WORD_W-2:0]  shift_q,      shift_d;
    logic [6:0]         led_idx_q,    led_idx_d;
    logic [63:0]        work_q,       work_d;
    logic [63:0]        bitmap_q,     bitmap_d;
    logic [7:0]         frame_cnt_q,  frame_cnt_d;
    logic               hdr_err_q,    hdr_err_d;
    logic               pix_valid_q,  pix_valid_d;
    logic [5:0]         pix_addr_q,   pix_addr_d;
    logic [4:0]         pix_bright_q, pix_bright_d;
    logic [7:0]         pix_b_q,      pix_b_d;
    logic [7:0]         pix_g_q,      pix_g_d;
    logic [7:0]         pix_r_q,      pix_r_d;
    logic               frame_done_q, frame_done_d;

    logic [WORD_W-1:0]  word_w;
    logic [5:0]         addr_w;

    assign word_w = {shift_q, bit_val};
    assign addr_w = unsnake(led_idx_q[5:0], ROW_LEN);

    always_comb begin
        state_d      = state_q;
        zcnt_d       = zcnt_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        led_idx_d    = led_idx_q;
        work_d       = work_q;
        bitmap_d     = bitmap_q;
        frame_cnt_d  = frame_cnt_q;
        hdr_err_d    = hdr_err_q;
        pix_valid_d  = 1'b0;
        pix_addr_d   = pix_addr_q;
        pix_bright_d = pix_bright_q;
        pix_b_d      = pix_b_q;
        pix_g_d      = pix_g_q;
        pix_r_d      = pix_r_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (bit_evt) begin
                    if (!bit_val) begin
                        if (zcnt_q != 6'(START_ZEROS)) begin
                            zcnt_d = zcnt_q + 6'd1;
                        end
                    end else if (zcnt_q == 6'(START_ZEROS)) begin
                        shift_d   = {{(WORD_W-2){1'b0}}, 1'b1};
                        bitcnt_d  = 6'd1;
                        led_idx_d = 7'd0;
                        state_d   = ST_WORD;
                    end else begin
                        zcnt_d = 6'd0;
                    end
                end
            end

            ST_WORD: begin
                if (bit_evt) begin
                    shift_d  = word_w[WORD_W-2:0];
                    bitcnt_d = bitcnt_q + 6'd1;
                    if (bitcnt_q == 6'(WORD_W - 1)) begin
                        bitcnt_d = 6'd0;
                        if (word_w[31:29] == LED_HDR) begin
                            pix_valid_d    = 1'b1;
                            pix_addr_d     = addr_w;
                            pix_bright_d   = word_w[28:24];
                            pix_b_d        = word_w[23:16];
                            pix_g_d        = word_w[15:8];
                            pix_r_d        = word_w[7:0];
                            work_d[addr_w] = (word_w == ON_WORD);
                            led_idx_d      = led_idx_q + 7'd1;
                            if (led_idx_d == 7'(NUM_LEDS)) begin
                                state_d = ST_DONE;
                            end
                        end else if (word_w == '0) begin
                            // An all-zero word is the driver's idle gap; treat as a full start run.
                            zcnt_d  = 6'(START_ZEROS);
                            state_d = ST_HUNT;
                        end else begin
                            hdr_err_d = 1'b1;
                            zcnt_d    = 6'd0;
                            state_d   = ST_HUNT;
                        end
                    end
                end
            end

            ST_DONE: begin
                bitmap_d     = work_q;
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 8'd1;
                work_d       = '0;
                zcnt_d       = 6'd0;
                state_d      = ST_HUNT;
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HUNT;
            zcnt_q       <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            led_idx_q    <= '0;
            work_q       <= '0;
            bitmap_q     <= '0;
            frame_cnt_q  <= '0;
            hdr_err_q    <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_addr_q   <= '0;
            pix_bright_q <= '0;
            pix_b_q      <= '0;
            pix_g_q      <= '0;
            pix_r_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            zcnt_q       <= zcnt_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            led_idx_q    <= led_idx_d;
            work_q       <= work_d;
            bitmap_q     <= bitmap_d;
            frame_cnt_q  <= frame_cnt_d;
            hdr_err_q    <= hdr_err_d;
            pix_valid_q  <= pix_valid_d;
            pix_addr_q   <= pix_addr_d;
            pix_bright_q <= pix_bright_d;
            pix_b_q      <= pix_b_d;
            pix_g_q      <= pix_g_d;
            pix_r_q      <= pix_r_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_addr   = pix_addr_q;
    assign pix_bright = pix_bright_q;
    assign pix_b      = pix_b_q;
    assign pix_g      = pix_g_q;
    assign pix_r      = pix_r_q;
    assign frame_done = frame_done_q;
    assign bitmap     = bitmap_q;
    assign frame_cnt  = frame_cnt_q;
    assign hdr_err    = hdr_err_q;

endmodule
`default_nettype wire
